// File: rtl/apb_seq_pkg.sv
// Shared types for the APB command sequencer: op codes, FSM states and the queued command payload.
// Command fields are sized for the widest supported bus; the top casts to its own ADDR_W/DATA_W.
package apb_seq_pkg;

  localparam int unsigned CMD_ADDR_W = 8;
  localparam int unsigned CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_WAIT  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_GAP    = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  typedef struct packed {
    op_t                   op;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_DATA_W-1:0] mask;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/apb_cmd_sequencer_if.sv
// APB bus bundle between the command sequencer (master) and the register block (slave).
interface apb_cmd_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_cmd_fifo.sv
// Circular command FIFO with wrap-bit pointers; push while full is dropped, push+pop in one cycle allowed.
module apb_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only read once the pointers mark them valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// APB master replaying queued WRITE/READ/POLL/WAIT commands, with wait states, delays and masked polling.
// Macro APB_CMD_SEQ_POLL_EN enables POLL; without it a POLL does no access and answers rsp_err=1, rsp_data=0.
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned POLL_MAX = 1024,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W-1:0]   cmd_mask,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                busy,
  apb_cmd_sequencer_if.master apb
);

  cmd_t   push_cmd;
  cmd_t   head;
  logic   full;
  logic   empty;
  logic   pop;

  state_t                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [CMD_DATA_W-1:0] cnt_q, cnt_d;

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef APB_CMD_SEQ_POLL_EN
  localparam int unsigned ATT_W = $clog2(POLL_MAX + 1);
  logic [ATT_W-1:0] attempt_q, attempt_d;
  logic             poll_hit;

  assign poll_hit = (((CMD_DATA_W'(apb.PRDATA)) ^ cmd_q.data) & cmd_q.mask) == '0;
`else
  logic unused_poll;
  assign unused_poll = ^{cmd_q.addr, cmd_q.data, cmd_q.mask, POLL_MAX[0], POLL_GAP[0]};
`endif

  assign push_cmd = '{op:   op_t'(cmd_op),
                      addr: CMD_ADDR_W'(cmd_addr),
                      data: CMD_DATA_W'(cmd_data),
                      mask: CMD_DATA_W'(cmd_mask)};

  apb_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .din   (push_cmd),
    .full  (full),
    .pop   (pop),
    .dout  (head),
    .empty (empty)
  );

  // Next-state and next-output logic; APB drive is computed here and registered below.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    paddr_d     = '0;
    pwrite_d    = 1'b0;
    pwdata_d    = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_CMD_SEQ_POLL_EN
    attempt_d   = attempt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          cmd_d = head;
          case (head.op)
            OP_WRITE, OP_READ: begin
              state_d  = S_SETUP;
              psel_d   = 1'b1;
              paddr_d  = ADDR_W'(head.addr);
              pwrite_d = (head.op == OP_WRITE);
              pwdata_d = (head.op == OP_WRITE) ? DATA_W'(head.data) : '0;
            end
            OP_POLL: begin
`ifdef APB_CMD_SEQ_POLL_EN
              state_d   = S_SETUP;
              psel_d    = 1'b1;
              paddr_d   = ADDR_W'(head.addr);
              attempt_d = '0;
`else
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = '0;
`endif
            end
            OP_WAIT: begin
              state_d = S_WAIT;
              cnt_d   = (head.data == '0) ? CMD_DATA_W'(1) : head.data;
            end
            default: ;
          endcase
        end
      end

      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
      end

      S_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        if (apb.PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          paddr_d   = '0;
          pwrite_d  = 1'b0;
          pwdata_d  = '0;
          state_d   = S_IDLE;
          case (cmd_q.op)
            OP_READ: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = apb.PRDATA;
              rsp_err_d   = 1'b0;
            end
`ifdef APB_CMD_SEQ_POLL_EN
            OP_POLL: begin
              if (poll_hit) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = apb.PRDATA;
                rsp_err_d   = 1'b0;
              end else if (attempt_q + ATT_W'(1) == ATT_W'(POLL_MAX)) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = apb.PRDATA;
                rsp_err_d   = 1'b1;
              end else begin
                attempt_d = attempt_q + ATT_W'(1);
                state_d   = S_GAP;
                cnt_d     = CMD_DATA_W'(POLL_GAP);
              end
            end
`endif
            default: ;
          endcase
        end
      end

      // Idle gap between poll attempts, then re-issue the same read.
      S_GAP: begin
        if (cnt_q <= CMD_DATA_W'(1)) begin
          state_d = S_SETUP;
          psel_d  = 1'b1;
          paddr_d = ADDR_W'(cmd_q.addr);
        end else begin
          cnt_d = cnt_q - CMD_DATA_W'(1);
        end
      end

      S_WAIT: begin
        if (cnt_q <= CMD_DATA_W'(1)) state_d = S_IDLE;
        else                         cnt_d   = cnt_q - CMD_DATA_W'(1);
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_CMD_SEQ_POLL_EN
      attempt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_CMD_SEQ_POLL_EN
      attempt_q   <= attempt_d;
`endif
    end
  end

  assign cmd_ready   = !full;
  assign busy        = (state_q != S_IDLE) || !empty;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;

endmodule
